lamp_mode_ctrl: RTL and testbench
=================================

Name: lamp_mode_ctrl

Overview:
- Lamp control FSM: the consumer of the auto-shutdown pulse C produced by the absence timer, and of the raw push-button and infrared presence inputs.
- Debounces the push-button and classifies each press as short or long.
- Keeps the system mode, AUTO or MANUAL, and drives the lamp output L.
- Sits between the sensor/button pins and the lamp driver, beside the absence timer.

Parameters:
DEBOUNCE_T, 100, number of consecutive high samples of push_button required before a press is accepted; must be >= 1.
LONG_PRESS_T, 5000, held-cycle count at which a press becomes a long press; must be > DEBOUNCE_T.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge).
push_button  input  1  raw user button, 1 = pressed, not debounced.
infravermelho  input  1  presence sensor, 1 = presence detected.
C  input  1  single-cycle shutdown pulse from the absence timer.
L  output  1  lamp drive, 1 = on; registered.
H  output  1  mode flag, 1 = MANUAL, 0 = AUTO; registered.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Button tracker goes to BTN_IDLE; counter = 0.
  - Lamp FSM goes to AUTO_OFF; L=0, H=0; internal events are cleared.
  - A button still held when rst returns to 1 is treated as a new press from count 1.
- Button tracker states: BTN_IDLE, BTN_DEB, BTN_HELD, BTN_LONG. Counter is $clog2(LONG_PRESS_T+1) bits wide and saturates at LONG_PRESS_T.
  - BTN_IDLE: push_button=1 -> BTN_DEB, cnt=1.
  - BTN_DEB: push_button=0 -> BTN_IDLE with no event (glitch). Otherwise cnt+1; when cnt reaches DEBOUNCE_T -> BTN_HELD.
  - BTN_HELD: push_button=0 -> short_evt high for exactly 1 cycle, then BTN_IDLE. Held with cnt reaching LONG_PRESS_T -> long_evt high for exactly 1 cycle, then BTN_LONG.
  - BTN_LONG: wait for push_button=0, then BTN_IDLE; no further event.
  - Net classification: held N consecutive cycles gives no event if N < DEBOUNCE_T, short if DEBOUNCE_T <= N < LONG_PRESS_T, long if N >= LONG_PRESS_T. Long fires while the button is still held; release after a long press is silent.
  - short_evt and long_evt are registered and never high in the same cycle.
- Lamp FSM states: AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON.
  - Evaluated every cycle with priority long_evt > short_evt > C > infravermelho.
  - long_evt toggles the mode and preserves lamp state: AUTO_x <-> MANUAL_x.
  - short_evt: MANUAL_OFF <-> MANUAL_ON; ignored in AUTO states.
  - C=1: AUTO_ON -> AUTO_OFF, even if infravermelho=1 in the same cycle; ignored in MANUAL states and in AUTO_OFF.
  - infravermelho=1: AUTO_OFF -> AUTO_ON; no effect elsewhere.
- Outputs:
  - L = 1 in AUTO_ON and MANUAL_ON; H = 1 in MANUAL_*.
  - Both registered: they update one cycle after the event is sampled.
- Latency from raw button edge:
  - Short press: L changes 2 cycles after the first push_button=0 sample (tracker register, then FSM register).
  - Long press: H changes 2 cycles after the sample at which the count reaches LONG_PRESS_T.
  - C or infravermelho to L: 1 cycle.
- Unused encodings of either state type recover to the IDLE / AUTO_OFF equivalents on the next clock.

Decomposition:
- Package lamp_ctrl_pkg:
  - typedef enum logic [1:0] btn_state_t {BTN_IDLE, BTN_DEB, BTN_HELD, BTN_LONG}.
  - typedef enum logic [1:0] lamp_state_t {AUTO_OFF, AUTO_ON, MANUAL_OFF, MANUAL_ON}.
- One sub-module, button_event_detector:
  - Ports: clk, rst, push_button -> short_evt, long_evt; parameters DEBOUNCE_T and LONG_PRESS_T.
  - Holds the tracker FSM and counter. The lamp FSM stays in lamp_mode_ctrl.

Test Plan (DEBOUNCE_T=4, LONG_PRESS_T=20):
- Reset: hold rst=0 for 3 cycles with push_button=1, infravermelho=1 -> L=0, H=0 throughout. After release, L=1 one cycle after the first sampled infravermelho=1.
- AUTO cycle: infravermelho=1 for 1 cycle -> L=1 next cycle. Later C=1 for 1 cycle -> L=0 next cycle. C=1 with infravermelho=1 in the same cycle -> L=0.
- Glitch rejection: push_button high 3 cycles, then low -> no event; H and L unchanged for 30 cycles.
- Long press: push_button high 25 cycles -> exactly one long_evt; H=1 and L preserved. Release produces no short_evt. C pulses now leave L unchanged.
- MANUAL toggles: in MANUAL_OFF, two presses of 8 cycles each separated by 10 low cycles -> L=1 after the first, L=0 after the second, each 2 cycles after release. Presence and C pulses are ignored.
- Reset mid-press: assert rst=0 at cycle 10 of a 25-cycle press -> no long_evt; H=0, L=0. A still-held button after reset re-debounces from count 1 and yields long_evt 20 cycles after reset release.

Source files
------------

// File: rtl/lamp_ctrl_pkg.sv
// Shared state types and small decode helpers for the lamp mode controller.
package lamp_ctrl_pkg;

    typedef enum logic [1:0] {
        BTN_IDLE,
        BTN_DEB,
        BTN_HELD,
        BTN_LONG
    } btn_state_t;

    typedef enum logic [1:0] {
        AUTO_OFF,
        AUTO_ON,
        MANUAL_OFF,
        MANUAL_ON
    } lamp_state_t;

    // Lamp is driven in both "on" states, whatever the mode.
    function automatic logic lamp_is_on(input lamp_state_t s);
        return (s == AUTO_ON) || (s == MANUAL_ON);
    endfunction

    // Mode flag: MANUAL states only.
    function automatic logic lamp_is_manual(input lamp_state_t s);
        return (s == MANUAL_OFF) || (s == MANUAL_ON);
    endfunction

endpackage

// File: rtl/lamp_mode_ctrl_button.sv
// Push-button debouncer and short/long press classifier.
// Emits one-cycle registered pulses: short_evt on release of a debounced
// press shorter than LONG_PRESS_T, long_evt while still held at LONG_PRESS_T.
module button_event_detector
    import lamp_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_T   = 100,
    parameter int LONG_PRESS_T = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    output logic short_evt,
    output logic long_evt
);

    localparam int CW = $clog2(LONG_PRESS_T + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DEB  = CW'(DEBOUNCE_T);
    localparam logic [CW-1:0] CNT_LONG = CW'(LONG_PRESS_T);

    btn_state_t    state;
    btn_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          short_nxt;
    logic          long_nxt;

    assign cnt_inc = cnt + CNT_ONE;

    // Tracker registers and event pulses; events clear on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= BTN_IDLE;
            cnt       <= '0;
            short_evt <= 1'b0;
            long_evt  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            short_evt <= short_nxt;
            long_evt  <= long_nxt;
        end
    end

    // Next-state logic: cnt holds the number of consecutive high samples
    // of the current press, saturating at LONG_PRESS_T in BTN_LONG.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        short_nxt = 1'b0;
        long_nxt  = 1'b0;
        case (state)
            BTN_IDLE: begin
                cnt_nxt = '0;
                if (push_button) begin
                    cnt_nxt   = CNT_ONE;
                    // A single-sample debounce accepts the press immediately.
                    state_nxt = (DEBOUNCE_T == 1) ? BTN_HELD : BTN_DEB;
                end
            end
            BTN_DEB: begin
                if (!push_button) begin
                    state_nxt = BTN_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_DEB) begin
                        state_nxt = BTN_HELD;
                    end
                end
            end
            BTN_HELD: begin
                if (!push_button) begin
                    short_nxt = 1'b1;
                    state_nxt = BTN_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_LONG) begin
                        long_nxt  = 1'b1;
                        state_nxt = BTN_LONG;
                    end
                end
            end
            BTN_LONG: begin
                // Counter stays saturated; release is silent.
                if (!push_button) begin
                    state_nxt = BTN_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = BTN_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/lamp_mode_ctrl.sv
// Lamp mode controller: AUTO/MANUAL mode and lamp drive from button
// events, the absence-timer shutdown pulse C and the presence sensor.
module lamp_mode_ctrl
    import lamp_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_T   = 100,
    parameter int LONG_PRESS_T = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    input  logic infravermelho,
    input  logic C,
    output logic L,
    output logic H
);

    logic        short_evt;
    logic        long_evt;
    lamp_state_t state;
    lamp_state_t state_nxt;

    button_event_detector #(
        .DEBOUNCE_T  (DEBOUNCE_T),
        .LONG_PRESS_T(LONG_PRESS_T)
    ) u_button (
        .clk        (clk),
        .rst        (rst),
        .push_button(push_button),
        .short_evt  (short_evt),
        .long_evt   (long_evt)
    );

    // Lamp FSM register; L and H are registered from the next state so they
    // change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= AUTO_OFF;
            L     <= 1'b0;
            H     <= 1'b0;
        end else begin
            state <= state_nxt;
            L     <= lamp_is_on(state_nxt);
            H     <= lamp_is_manual(state_nxt);
        end
    end

    // Transitions with priority long_evt > short_evt > C > infravermelho.
    // An event that does not apply in the current state falls through to
    // the next one in priority order.
    always_comb begin
        state_nxt = state;
        case (state)
            AUTO_OFF: begin
                if (long_evt) begin
                    state_nxt = MANUAL_OFF;
                end else if (infravermelho) begin
                    state_nxt = AUTO_ON;
                end
            end
            AUTO_ON: begin
                if (long_evt) begin
                    state_nxt = MANUAL_ON;
                end else if (C) begin
                    state_nxt = AUTO_OFF;
                end
            end
            MANUAL_OFF: begin
                if (long_evt) begin
                    state_nxt = AUTO_OFF;
                end else if (short_evt) begin
                    state_nxt = MANUAL_ON;
                end
            end
            MANUAL_ON: begin
                if (long_evt) begin
                    state_nxt = AUTO_ON;
                end else if (short_evt) begin
                    state_nxt = MANUAL_OFF;
                end
            end
            default: begin
                state_nxt = AUTO_OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_lamp_mode_ctrl.sv
// Self-checking bench for lamp_mode_ctrl with DEBOUNCE_T=4, LONG_PRESS_T=20.
module tb_lamp_mode_ctrl;

    localparam int DEB_T  = 4;
    localparam int LONG_T = 20;

    logic clk;
    logic rst;
    logic push_button;
    logic infravermelho;
    logic C;
    logic L;
    logic H;

    int n_checks;
    int n_pass;

    // Scoreboard: expected {H, L} after each clock edge.
    logic [1:0] exp_q[$];

    // Reference model: run length of the current press plus mode/lamp bits.
    int   m_run;
    logic m_short;
    logic m_long;
    logic m_manual;
    logic m_lamp;

    typedef struct {
        logic rst;
        logic pb;
        logic ir;
        logic c;
        logic exp_l;
        logic exp_h;
    } vec_t;

    vec_t vecs[12];

    lamp_mode_ctrl #(
        .DEBOUNCE_T  (DEB_T),
        .LONG_PRESS_T(LONG_T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .push_button  (push_button),
        .infravermelho(infravermelho),
        .C            (C),
        .L            (L),
        .H            (H)
    );

    // Clock and initial input levels.
    initial begin
        clk           = 1'b0;
        rst           = 1'b0;
        push_button   = 1'b0;
        infravermelho = 1'b0;
        C             = 1'b0;
    end
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] actual, input logic [1:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Events produced at one edge take effect at the next edge; the press
    // length decides which event (if any) a press produces.
    task automatic model_update(input logic r, input logic p, input logic i, input logic cc);
        logic n_short;
        logic n_long;
        if (!r) begin
            m_run    = 0;
            m_short  = 1'b0;
            m_long   = 1'b0;
            m_manual = 1'b0;
            m_lamp   = 1'b0;
            return;
        end
        if (m_long) begin
            m_manual = !m_manual;
        end else if (m_short && m_manual) begin
            m_lamp = !m_lamp;
        end else if (!m_manual) begin
            if (m_lamp && cc) m_lamp = 1'b0;
            else if (!m_lamp && i) m_lamp = 1'b1;
        end
        n_short = 1'b0;
        n_long  = 1'b0;
        if (p) begin
            m_run  = m_run + 1;
            n_long = (m_run == LONG_T);
        end else begin
            n_short = (m_run >= DEB_T) && (m_run < LONG_T);
            m_run   = 0;
        end
        m_short = n_short;
        m_long  = n_long;
    endtask

    // Driver: apply inputs for one cycle, advance the model on the edge,
    // compare outputs on the following falling edge.
    task automatic step(input logic r, input logic p, input logic i, input logic cc);
        logic [1:0] e;
        rst           = r;
        push_button   = p;
        infravermelho = i;
        C             = cc;
        @(posedge clk);
        model_update(r, p, i, cc);
        exp_q.push_back({m_manual, m_lamp});
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 2'b00, 2'b11);
        end else begin
            e = exp_q.pop_front();
            check("scoreboard", {H, L}, e);
        end
    endtask

    // Press for 'hold' cycles, then release; L is checked on the first
    // two low samples (unchanged, then toggled).
    task automatic press(input int hold, input int low, input logic l_before,
                         input logic l_after, input string name);
        for (int k = 0; k < hold; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check({name, "_rel1"}, {1'b0, L}, {1'b0, l_before});
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check({name, "_rel2"}, {1'b0, L}, {1'b0, l_after});
        for (int k = 2; k < low; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int remaining;
        logic pb_lvl;
        logic r_in;
        n_checks = 0;
        n_pass   = 0;
        m_run    = 0;
        m_short  = 1'b0;
        m_long   = 1'b0;
        m_manual = 1'b0;
        m_lamp   = 1'b0;

        // Reset with button and presence active, then the AUTO cycle.
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].rst, vecs[v].pb, vecs[v].ir, vecs[v].c);
            check($sformatf("vec%0d", v), {H, L}, {vecs[v].exp_h, vecs[v].exp_l});
        end

        // Glitch: 3 high samples is below the debounce threshold.
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("glitch_hold", {H, L}, 2'b00);

        // Long press with lamp on: mode flips, lamp preserved.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("ir_on", {H, L}, 2'b01);
        for (int k = 1; k <= 25; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (k == 20) check("long_pre", {H, L}, 2'b01);
            if (k == 21) check("long_toggle", {H, L}, 2'b11);
        end
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("long_release_silent", {H, L}, 2'b11);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("manual_c_ignored", {H, L}, 2'b11);

        // MANUAL toggles, including debounce and long-threshold boundaries.
        press(8, 10, 1'b1, 1'b0, "man_off0");
        press(8, 10, 1'b0, 1'b1, "man_on1");
        press(8, 10, 1'b1, 1'b0, "man_off2");
        press(DEB_T, 10, 1'b0, 1'b1, "deb_edge");
        press(LONG_T - 1, 10, 1'b1, 1'b0, "long_minus1");
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("manual_ir_ignored", {H, L}, 2'b10);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("manual_c_ignored2", {H, L}, 2'b10);
        for (int k = 0; k < LONG_T; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        check("long_exact_pre", {H, L}, 2'b10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("long_exact_auto", {H, L}, 2'b00);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a press, button held through reset.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("ir_on2", {H, L}, 2'b01);
        for (int k = 1; k < 10; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("rst_mid", {H, L}, 2'b00);
        for (int k = 1; k <= 25; k++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (k == 20) check("rst_relong_pre", {H, L}, 2'b00);
            if (k == 21) check("rst_relong", {H, L}, 2'b10);
        end
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        remaining = 0;
        pb_lvl    = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (remaining == 0) begin
                pb_lvl    = !pb_lvl;
                remaining = pb_lvl ? $urandom_range(1, 26) : $urandom_range(1, 12);
            end
            remaining--;
            r_in = ($urandom_range(0, 399) != 0);
            step(r_in, pb_lvl, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
